// File: rtl/n64adv_rst_sequencer.sv
// Reset housekeeping: releases NCH active-low domain resets in order, gated by
// synchronised PLL locks, with per-channel config-change reset pulses.
module n64adv_rst_sequencer #(
  parameter int unsigned    NCH         = 3,
  parameter int unsigned    CFG_W       = 2,
  parameter int unsigned    HOLD_W      = 4,
  parameter int unsigned    LOCK_STABLE = 4,
  parameter int unsigned    SEQ_GAP     = 8,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [NCH-1:0] LOCK_USED   = {NCH{1'b1}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       LOCKED_i,
  input  logic [NCH*CFG_W-1:0] CFG_i,
  output logic [NCH-1:0]       nRST_o,
  output logic                 ALL_RDY,
  output logic [1:0]           SEQ_STATE,
  output logic [3:0]           SEQ_PTR,
  output logic [7:0]           LOSS_CNT
);

  localparam int unsigned PTR_W   = $clog2(NCH + 1);
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);
  localparam int unsigned GAP_W   = $clog2(SEQ_GAP + 1);
  localparam int unsigned CFG_TOT = NCH * CFG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_GAP  = 2'b10,
    S_RUN  = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0][NCH-1:0]     lock_sync_q;
  logic [SYNC_STAGES-1:0][CFG_TOT-1:0] cfg_sync_q;
  logic [CFG_TOT-1:0]                  cfg_d_q;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [STB_W-1:0]        stable_q, stable_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [7:0]              loss_cnt_q, loss_cnt_d;
  logic [NCH-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [NCH-1:0]          nrst_q, nrst_d;
  logic                    all_rdy_q, all_rdy_d;

  logic [NCH-1:0]          locked_s;
  logic [CFG_TOT-1:0]      cfg_s;
  logic                    lock_at_ptr;
  logic                    loss;
  logic [PTR_W-1:0]        loss_idx;

  // Unused lock inputs read as permanently locked
  assign locked_s = lock_sync_q[SYNC_STAGES-1] | ~LOCK_USED;
  assign cfg_s    = cfg_sync_q[SYNC_STAGES-1];

  // Input synchronisers plus one extra config stage for change detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_sync_q <= '0;
      cfg_sync_q  <= '0;
      cfg_d_q     <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], LOCKED_i};
      cfg_sync_q  <= {cfg_sync_q[SYNC_STAGES-2:0], CFG_i};
      cfg_d_q     <= cfg_s;
    end
  end

  // Lock at the channel currently waiting, and lowest already-released lost lock
  always_comb begin
    lock_at_ptr = 1'b0;
    loss        = 1'b0;
    loss_idx    = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (ptr_q == PTR_W'(k)) lock_at_ptr = locked_s[k];
    end
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if ((PTR_W'(k) < ptr_q) && !locked_s[k]) begin
        loss     = 1'b1;
        loss_idx = PTR_W'(k);
      end
    end
  end

  // Sequencer next state, config holds and registered reset outputs
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    stable_d   = stable_q;
    gap_d      = gap_q;
    loss_cnt_d = loss_cnt_q;
    hold_d     = hold_q;
    nrst_d     = '0;
    all_rdy_d  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (lock_at_ptr) begin
          if (stable_q == STB_W'(LOCK_STABLE - 1)) begin
            ptr_d    = ptr_q + PTR_W'(1);
            stable_d = '0;
            gap_d    = '0;
            state_d  = ((ptr_q + PTR_W'(1)) < PTR_W'(NCH)) ? S_GAP : S_RUN;
          end else begin
            stable_d = stable_q + STB_W'(1);
          end
        end else begin
          stable_d = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(SEQ_GAP - 1)) begin
          gap_d   = '0;
          state_d = S_WAIT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase

    // Lock loss overrides normal sequencing; simultaneous losses are one event
    if ((state_q != S_IDLE) && loss) begin
      ptr_d    = loss_idx;
      state_d  = S_WAIT;
      stable_d = '0;
      gap_d    = '0;
      if (loss_cnt_q != 8'hff) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    for (int k = 0; k < int'(NCH); k++) begin
      if (cfg_s[k*CFG_W +: CFG_W] != cfg_d_q[k*CFG_W +: CFG_W]) begin
        hold_d[k] = {HOLD_W{1'b1}};
      end else if (hold_q[k] != '0) begin
        hold_d[k] = hold_q[k] - HOLD_W'(1);
      end
      nrst_d[k] = (PTR_W'(k) < ptr_d) && (hold_d[k] == '0);
    end
    all_rdy_d = &nrst_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      stable_q   <= '0;
      gap_q      <= '0;
      loss_cnt_q <= '0;
      hold_q     <= '0;
      nrst_q     <= '0;
      all_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      stable_q   <= stable_d;
      gap_q      <= gap_d;
      loss_cnt_q <= loss_cnt_d;
      hold_q     <= hold_d;
      nrst_q     <= nrst_d;
      all_rdy_q  <= all_rdy_d;
    end
  end

  assign nRST_o    = nrst_q;
  assign ALL_RDY   = all_rdy_q;
  assign SEQ_STATE = state_q;
  assign SEQ_PTR   = 4'(ptr_q);
  assign LOSS_CNT  = loss_cnt_q;

endmodule

// File: tb/tb_n64adv_rst_sequencer.sv
// Directed bench for n64adv_rst_sequencer: ordered release, stall, lock loss,
// config holds, loss-counter saturation and an ignored-lock channel.
module tb_n64adv_rst_sequencer;

  logic       clk;
  logic       rst, rst6;
  logic [2:0] locked, locked6;
  logic [5:0] cfg, cfg6;
  logic [2:0] nrst, nrst6;
  logic       all_rdy, all_rdy6;
  logic [1:0] seq_state, seq_state6;
  logic [3:0] seq_ptr, seq_ptr6;
  logic [7:0] loss_cnt, loss_cnt6;

  int tests = 0;
  int fails = 0;

  n64adv_rst_sequencer #(
    .NCH(3), .CFG_W(2), .HOLD_W(4), .LOCK_STABLE(4), .SEQ_GAP(8), .SYNC_STAGES(2),
    .LOCK_USED(3'b111)
  ) dut (
    .CLK(clk), .RST(rst), .LOCKED_i(locked), .CFG_i(cfg), .nRST_o(nrst),
    .ALL_RDY(all_rdy), .SEQ_STATE(seq_state), .SEQ_PTR(seq_ptr), .LOSS_CNT(loss_cnt)
  );

  n64adv_rst_sequencer #(
    .NCH(3), .CFG_W(2), .HOLD_W(4), .LOCK_STABLE(4), .SEQ_GAP(8), .SYNC_STAGES(2),
    .LOCK_USED(3'b110)
  ) dut6 (
    .CLK(clk), .RST(rst6), .LOCKED_i(locked6), .CFG_i(cfg6), .nRST_o(nrst6),
    .ALL_RDY(all_rdy6), .SEQ_STATE(seq_state6), .SEQ_PTR(seq_ptr6), .LOSS_CNT(loss_cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; rst6 = 1'b1; locked = 3'b111; cfg = '0; locked6 = 3'b000; cfg6 = '0;
    repeat (3) @(negedge clk);
    tests++; if (nrst !== 3'b000) begin $display("FAIL reset_nrst got %b exp 000", nrst); fails++; end
    tests++; if (all_rdy !== 1'b0) begin $display("FAIL reset_all_rdy got %b exp 0", all_rdy); fails++; end
    tests++; if (seq_state !== 2'b00) begin $display("FAIL reset_state got %b exp 00", seq_state); fails++; end
    tests++; if (seq_ptr !== 4'd0) begin $display("FAIL reset_ptr got %0d exp 0", seq_ptr); fails++; end
    tests++; if (loss_cnt !== 8'd0) begin $display("FAIL reset_loss got %0d exp 0", loss_cnt); fails++; end
    tests++; if (nrst6 !== 3'b000) begin $display("FAIL reset_nrst6 got %b exp 000", nrst6); fails++; end
  endtask

  task automatic test_sequence();
    int cyc;
    rst = 1'b0;
    cyc = 0;
    while (nrst !== 3'b001 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 6) begin $display("FAIL seq_ch0_time got %0d exp 6", cyc); fails++; end
    cyc = 0;
    while (nrst !== 3'b011 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 12) begin $display("FAIL seq_ch1_time got %0d exp 12", cyc); fails++; end
    tests++; if (all_rdy !== 1'b0) begin $display("FAIL seq_rdy_early got %b exp 0", all_rdy); fails++; end
    cyc = 0;
    while (nrst !== 3'b111 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 12) begin $display("FAIL seq_ch2_time got %0d exp 12", cyc); fails++; end
    tests++; if (all_rdy !== 1'b1) begin $display("FAIL seq_all_rdy got %b exp 1", all_rdy); fails++; end
    tests++; if (seq_state !== 2'b11) begin $display("FAIL seq_state got %b exp 11", seq_state); fails++; end
    tests++; if (seq_ptr !== 4'd3) begin $display("FAIL seq_ptr got %0d exp 3", seq_ptr); fails++; end
  endtask

  task automatic test_stall();
    int cyc;
    rst = 1'b1; locked = 3'b101;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (nrst !== 3'b001 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 6) begin $display("FAIL stall_ch0_time got %0d exp 6", cyc); fails++; end
    repeat (40) @(negedge clk);
    tests++; if (nrst !== 3'b001) begin $display("FAIL stall_nrst got %b exp 001", nrst); fails++; end
    tests++; if (seq_state !== 2'b01) begin $display("FAIL stall_state got %b exp 01", seq_state); fails++; end
    tests++; if (seq_ptr !== 4'd1) begin $display("FAIL stall_ptr got %0d exp 1", seq_ptr); fails++; end
    locked = 3'b111;
    cyc = 0;
    while (nrst !== 3'b011 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 6) begin $display("FAIL stall_ch1_time got %0d exp 6", cyc); fails++; end
    cyc = 0;
    while (nrst !== 3'b111 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 12) begin $display("FAIL stall_ch2_time got %0d exp 12", cyc); fails++; end
  endtask

  task automatic test_lock_loss();
    int cyc;
    locked = 3'b101;
    @(negedge clk);
    locked = 3'b111;
    cyc = 1;
    while (nrst !== 3'b001 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 3) begin $display("FAIL loss_time got %0d exp 3", cyc); fails++; end
    tests++; if (loss_cnt !== 8'd1) begin $display("FAIL loss_cnt got %0d exp 1", loss_cnt); fails++; end
    tests++; if (seq_ptr !== 4'd1) begin $display("FAIL loss_ptr got %0d exp 1", seq_ptr); fails++; end
    tests++; if (seq_state !== 2'b01) begin $display("FAIL loss_state got %b exp 01", seq_state); fails++; end
    cyc = 0;
    while (nrst !== 3'b011 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 4) begin $display("FAIL loss_ch1_time got %0d exp 4", cyc); fails++; end
    cyc = 0;
    while (nrst !== 3'b111 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 12) begin $display("FAIL loss_ch2_time got %0d exp 12", cyc); fails++; end
  endtask

  task automatic test_cfg_hold();
    int low, rdy_low, other, first;
    low = 0; rdy_low = 0; other = 0; first = -1;
    cfg = 6'b000001;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (nrst[0] === 1'b0) begin low++; if (first < 0) first = i; end
      if (nrst[2:1] !== 2'b11) other++;
      if (all_rdy === 1'b0) rdy_low++;
    end
    tests++; if (first !== 3) begin $display("FAIL hold_start got %0d exp 3", first); fails++; end
    tests++; if (low !== 15) begin $display("FAIL hold_len got %0d exp 15", low); fails++; end
    tests++; if (rdy_low !== 15) begin $display("FAIL hold_rdy_len got %0d exp 15", rdy_low); fails++; end
    tests++; if (other !== 0) begin $display("FAIL hold_others got %0d exp 0", other); fails++; end
    low = 0; rdy_low = 0; other = 0; first = -1;
    cfg = 6'b000010;
    for (int i = 1; i <= 50; i++) begin
      if (i == 6) cfg = 6'b000011;
      @(negedge clk);
      if (nrst[0] === 1'b0) begin low++; if (first < 0) first = i; end
      if (nrst[2:1] !== 2'b11) other++;
      if (all_rdy === 1'b0) rdy_low++;
    end
    tests++; if (first !== 3) begin $display("FAIL rehold_start got %0d exp 3", first); fails++; end
    tests++; if (low !== 20) begin $display("FAIL rehold_len got %0d exp 20", low); fails++; end
    tests++; if (rdy_low !== 20) begin $display("FAIL rehold_rdy_len got %0d exp 20", rdy_low); fails++; end
    tests++; if (other !== 0) begin $display("FAIL rehold_others got %0d exp 0", other); fails++; end
    tests++; if (seq_ptr !== 4'd3) begin $display("FAIL rehold_ptr got %0d exp 3", seq_ptr); fails++; end
  endtask

  task automatic test_multi_loss();
    int cyc;
    tests++; if (all_rdy !== 1'b1) begin $display("FAIL mloss_pre_rdy got %b exp 1", all_rdy); fails++; end
    locked = 3'b010;
    cyc = 0;
    while (nrst !== 3'b000 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 3) begin $display("FAIL mloss_time got %0d exp 3", cyc); fails++; end
    tests++; if (seq_ptr !== 4'd0) begin $display("FAIL mloss_ptr got %0d exp 0", seq_ptr); fails++; end
    tests++; if (loss_cnt !== 8'd2) begin $display("FAIL mloss_cnt got %0d exp 2", loss_cnt); fails++; end
    repeat (10) @(negedge clk);
    tests++; if (loss_cnt !== 8'd2) begin $display("FAIL mloss_cnt_hold got %0d exp 2", loss_cnt); fails++; end
    for (int i = 0; i < 300; i++) begin
      locked = 3'b111;
      repeat (10) @(negedge clk);
      locked = 3'b110;
      repeat (4) @(negedge clk);
      if (i == 0) begin
        tests++; if (loss_cnt !== 8'd3) begin $display("FAIL toggle_first got %0d exp 3", loss_cnt); fails++; end
      end
    end
    tests++; if (loss_cnt !== 8'hff) begin $display("FAIL loss_sat got %0d exp 255", loss_cnt); fails++; end
    tests++; if (nrst !== 3'b000) begin $display("FAIL toggle_nrst got %b exp 000", nrst); fails++; end
  endtask

  task automatic test_lock_unused();
    int cyc;
    rst6 = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (nrst6 !== 3'b001) begin $display("FAIL unused_nrst got %b exp 001", nrst6); fails++; end
    tests++; if (seq_ptr6 !== 4'd1) begin $display("FAIL unused_ptr got %0d exp 1", seq_ptr6); fails++; end
    tests++; if (seq_state6 !== 2'b01) begin $display("FAIL unused_state got %b exp 01", seq_state6); fails++; end
    tests++; if (loss_cnt6 !== 8'd0) begin $display("FAIL unused_loss got %0d exp 0", loss_cnt6); fails++; end
    rst6 = 1'b1;
    repeat (2) @(negedge clk);
    rst6 = 1'b0;
    cyc = 0;
    while (nrst6 !== 3'b001 && cyc < 60) begin @(negedge clk); cyc++; end
    tests++; if (cyc !== 5) begin $display("FAIL unused_ch0_time got %0d exp 5", cyc); fails++; end
    repeat (3) @(negedge clk);
    tests++; if (seq_state6 !== 2'b10) begin $display("FAIL unused_gap got %b exp 10", seq_state6); fails++; end
    rst6 = 1'b1;
    @(negedge clk);
    tests++; if (nrst6 !== 3'b000) begin $display("FAIL midgap_nrst got %b exp 000", nrst6); fails++; end
    tests++; if (all_rdy6 !== 1'b0) begin $display("FAIL midgap_rdy got %b exp 0", all_rdy6); fails++; end
    tests++; if (seq_state6 !== 2'b00) begin $display("FAIL midgap_state got %b exp 00", seq_state6); fails++; end
    tests++; if (seq_ptr6 !== 4'd0) begin $display("FAIL midgap_ptr got %0d exp 0", seq_ptr6); fails++; end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_lock_loss();
    test_cfg_hold();
    test_multi_loss();
    test_lock_unused();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
